// File: rtl/input_sel_pkg.sv
// Shared types and helpers for the input stream selector.
package input_sel_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } selState_e;

  localparam logic ORIGIN_MAIN = 1'b0;
  localparam logic ORIGIN_REGS = 1'b1;

  // Bit offset of digit idx inside a packed digit vector.
  function automatic int unsigned digitLsb(input int unsigned idx, input int unsigned digitW);
    return idx * digitW;
  endfunction

endpackage

// File: rtl/digit_mux.sv
// Combinational select of one digit from a packed digit vector.
module digit_mux
  import input_sel_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned DIGITS  = 16,
  localparam int unsigned IDX_W  = $clog2(DIGITS)
) (
  input  logic [DIGITS*DIGIT_W-1:0] data,
  input  logic [IDX_W-1:0]          idx,
  output logic [DIGIT_W-1:0]        digit
);

  assign digit = data[digitLsb(32'(idx), DIGIT_W) +: DIGIT_W];

endmodule

// File: rtl/input_stream_selector.sv
// Streams a burst of consecutive digits from one of two packed sources, one per unstalled cycle.
// Optional INPUT_STREAM_SELECTOR_DESC_EN adds wDir to walk the pointer downwards.
module input_stream_selector
  import input_sel_pkg::*;
#(
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned MAIN_DIGITS = 16,
  parameter int unsigned REGS_DIGITS = 64,
  parameter int unsigned CNT_W       = 7,
  localparam int unsigned MAIN_IDX_W = $clog2(MAIN_DIGITS),
  localparam int unsigned REGS_IDX_W = $clog2(REGS_DIGITS)
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic                           wStart,
  input  logic                           wBusy,
  input  logic                           wSelecOrigin,
`ifdef INPUT_STREAM_SELECTOR_DESC_EN
  input  logic                           wDir,
`endif
  input  logic [MAIN_DIGITS*DIGIT_W-1:0] wData,
  input  logic [REGS_DIGITS*DIGIT_W-1:0] wDataRegs,
  input  logic [MAIN_IDX_W-1:0]          wSelecMain,
  input  logic [REGS_IDX_W-1:0]          wSelecRegs,
  input  logic [CNT_W-1:0]               wCount,
  output logic [DIGIT_W-1:0]             r,
  output logic                           rValid,
  output logic                           rDone,
  output logic                           rActive
);

  localparam int unsigned PTR_W = (MAIN_IDX_W > REGS_IDX_W) ? MAIN_IDX_W : REGS_IDX_W;
  // Sources are powers of two, so masking the stepped pointer gives the wrap.
  localparam logic [PTR_W-1:0] MainMask = PTR_W'((64'd1 << MAIN_IDX_W) - 64'd1);
  localparam logic [PTR_W-1:0] RegsMask = PTR_W'((64'd1 << REGS_IDX_W) - 64'd1);

  selState_e          stateQ, stateD;
  logic               originQ, originD;
  logic [PTR_W-1:0]   ptrQ, ptrD, ptrStep;
  logic [CNT_W-1:0]   remQ, remD;
  logic [DIGIT_W-1:0] rD, mainDigit, regsDigit, curDigit;
  logic               rValidD, rDoneD;
`ifdef INPUT_STREAM_SELECTOR_DESC_EN
  logic               dirQ, dirD;
`endif

  digit_mux #(
    .DIGIT_W(DIGIT_W),
    .DIGITS (MAIN_DIGITS)
  ) uMainMux (
    .data (wData),
    .idx  (ptrQ[MAIN_IDX_W-1:0]),
    .digit(mainDigit)
  );

  digit_mux #(
    .DIGIT_W(DIGIT_W),
    .DIGITS (REGS_DIGITS)
  ) uRegsMux (
    .data (wDataRegs),
    .idx  (ptrQ[REGS_IDX_W-1:0]),
    .digit(regsDigit)
  );

  assign curDigit = (originQ == ORIGIN_MAIN) ? mainDigit : regsDigit;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: if (wStart) stateD = (wCount != '0) ? StRun : StDone;
      StRun:  if (!wBusy && remQ == CNT_W'(1)) stateD = StDone;
      StDone: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Burst bookkeeping: origin, pointer and remaining count
  always_comb begin
`ifdef INPUT_STREAM_SELECTOR_DESC_EN
    dirD    = dirQ;
    ptrStep = dirQ ? (ptrQ - PTR_W'(1)) : (ptrQ + PTR_W'(1));
`else
    ptrStep = ptrQ + PTR_W'(1);
`endif
    originD = originQ;
    ptrD    = ptrQ;
    remD    = remQ;
    if (stateQ == StIdle && wStart) begin
      originD = wSelecOrigin;
      ptrD    = (wSelecOrigin == ORIGIN_MAIN) ? PTR_W'(wSelecMain) : PTR_W'(wSelecRegs);
      remD    = wCount;
`ifdef INPUT_STREAM_SELECTOR_DESC_EN
      dirD    = wDir;
`endif
    end else if (stateQ == StRun && !wBusy) begin
      ptrD = ptrStep & ((originQ == ORIGIN_MAIN) ? MainMask : RegsMask);
      remD = remQ - CNT_W'(1);
    end
  end

  // Output logic
  always_comb begin
    rD      = r;
    rValidD = 1'b0;
    rDoneD  = 1'b0;
    rActive = (stateQ == StRun) || (stateQ == StDone);
    unique case (stateQ)
      StRun: begin
        if (!wBusy) begin
          rD      = curDigit;
          rValidD = 1'b1;
        end
      end
      StDone:  rDoneD = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      originQ <= ORIGIN_MAIN;
      ptrQ    <= '0;
      remQ    <= '0;
      r       <= '0;
      rValid  <= 1'b0;
      rDone   <= 1'b0;
`ifdef INPUT_STREAM_SELECTOR_DESC_EN
      dirQ    <= 1'b0;
`endif
    end else begin
      originQ <= originD;
      ptrQ    <= ptrD;
      remQ    <= remD;
      r       <= rD;
      rValid  <= rValidD;
      rDone   <= rDoneD;
`ifdef INPUT_STREAM_SELECTOR_DESC_EN
      dirQ    <= dirD;
`endif
    end
  end

endmodule

// File: tb/tb_input_stream_selector.sv
// Scoreboard bench for input_stream_selector: stimulus pushes expected digits and done markers,
// a negedge monitor pops and compares them whenever rValid or rDone is seen.
module tb_input_stream_selector;

  typedef struct packed {
    logic       isDone;
    logic [3:0] digit;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic         wStart = 1'b0;
  logic         wBusy = 1'b0;
  logic         wSelecOrigin = 1'b0;
  logic         wDir = 1'b0;
  logic [63:0]  wData = 64'h0123456789abcdef;
  logic [255:0] wDataRegs =
    256'h6789abcdef0123456789abcdef0123456789abcdef0123456789abcdef012345;
  logic [3:0]   wSelecMain = '0;
  logic [5:0]   wSelecRegs = '0;
  logic [6:0]   wCount = '0;
  logic [3:0]   r;
  logic         rValid, rDone, rActive;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nPass = 0;

  input_stream_selector dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .wStart      (wStart),
    .wBusy       (wBusy),
    .wSelecOrigin(wSelecOrigin),
`ifdef INPUT_STREAM_SELECTOR_DESC_EN
    .wDir        (wDir),
`endif
    .wData       (wData),
    .wDataRegs   (wDataRegs),
    .wSelecMain  (wSelecMain),
    .wSelecRegs  (wSelecRegs),
    .wCount      (wCount),
    .r           (r),
    .rValid      (rValid),
    .rDone       (rDone),
    .rActive     (rActive)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic popCheck(input logic isDone, input logic [3:0] digit);
    exp_t e;
    if (expQ.size() == 0) begin
      nChecks++;
      $display("FAIL unexpected_output: got done=%0b r=%0h, expected nothing at %0t",
               isDone, digit, $time);
    end else begin
      e = expQ.pop_front();
      check(isDone ? "stream_done" : "stream_digit", 32'({isDone, digit}),
            32'({e.isDone, e.digit}));
    end
  endtask

  // Monitor: every presented digit or done pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rValid === 1'b1) popCheck(1'b0, r);
    if (rDone === 1'b1) popCheck(1'b1, 4'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushDigit(input logic [3:0] d);
    exp_t e;
    e.isDone = 1'b0;
    e.digit  = d;
    expQ.push_back(e);
  endtask

  task automatic pushDone();
    exp_t e;
    e.isDone = 1'b1;
    e.digit  = 4'h0;
    expQ.push_back(e);
  endtask

  // Issues the start edge; selectors are scrambled afterwards since they are don't-care.
  task automatic startBurst(input logic origin, input logic [3:0] selM, input logic [5:0] selR,
                            input logic [6:0] cnt, input logic dir);
    wSelecOrigin = origin;
    wSelecMain   = selM;
    wSelecRegs   = selR;
    wCount       = cnt;
    wDir         = dir;
    wStart       = 1'b1;
    tick();
    wStart       = 1'b0;
    wSelecOrigin = ~origin;
    wSelecMain   = ~selM;
    wSelecRegs   = ~selR;
    wCount       = ~cnt;
    wDir         = ~dir;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("reset_r", 32'(r), 32'd0);
    check("reset_rValid", 32'(rValid), 32'd0);
    check("reset_rDone", 32'(rDone), 32'd0);
    check("reset_rActive", 32'(rActive), 32'd0);
    reset_L = 1'b1;
    tick();

    // Main source wrap 15 -> 0
    pushDigit(4'h1); pushDigit(4'h0); pushDigit(4'hf); pushDigit(4'he); pushDone();
    startBurst(1'b0, 4'd14, 6'd0, 7'd4, 1'b0);
    check("main_rActive", 32'(rActive), 32'd1);
    check("main_rValid_early", 32'(rValid), 32'd0);
    tick();
    check("main_first_latency", 32'({rValid, r}), 32'({1'b1, 4'h1}));
    waitDrain("main_drain");

    // Register source wrap 63 -> 0
    pushDigit(4'h7); pushDigit(4'h6); pushDigit(4'h5); pushDone();
    startBurst(1'b1, 4'd0, 6'd62, 7'd3, 1'b0);
    waitDrain("regs_drain");

    // Two-cycle stall after the first digit; a stray wStart during RUN is ignored
    pushDigit(4'hf); pushDigit(4'he); pushDigit(4'hd); pushDone();
    startBurst(1'b0, 4'd0, 6'd0, 7'd3, 1'b0);
    tick();
    wBusy  = 1'b1;
    wStart = 1'b1;
    tick();
    check("stall1", 32'({rValid, r, rActive}), 32'({1'b0, 4'hf, 1'b1}));
    wStart = 1'b0;
    tick();
    check("stall2", 32'({rValid, r}), 32'({1'b0, 4'hf}));
    wBusy = 1'b0;
    waitDrain("stall_drain");

    // Zero count goes straight to DONE
    pushDone();
    startBurst(1'b0, 4'd3, 6'd0, 7'd0, 1'b0);
    check("zero_rActive", 32'({rActive, rValid}), 32'({1'b1, 1'b0}));
    tick();
    check("zero_rDone", 32'({rDone, rValid}), 32'({1'b1, 1'b0}));
    waitDrain("zero_drain");

    // Reset after the second digit aborts the burst without rDone
    pushDigit(4'hf); pushDigit(4'he);
    startBurst(1'b0, 4'd0, 6'd0, 7'd5, 1'b0);
    tick();
    tick();
    reset_L = 1'b0;
    tick();
    check("abort_outputs", 32'({r, rValid, rActive, rDone}), 32'd0);
    tick();
    reset_L = 1'b1;
    repeat (8) tick();
    check("abort_drain", 32'(expQ.size()), 32'd0);

    // Fresh start after the abort
    pushDigit(4'ha); pushDigit(4'h9); pushDone();
    startBurst(1'b0, 4'd5, 6'd0, 7'd2, 1'b0);
    waitDrain("restart_drain");

    // r holds its last value while idle
    repeat (3) tick();
    check("idle_hold", 32'({r, rValid, rActive}), 32'({4'h9, 1'b0, 1'b0}));

`ifdef INPUT_STREAM_SELECTOR_DESC_EN
    // Descending walk wraps 0 -> 15
    pushDigit(4'he); pushDigit(4'hf); pushDigit(4'h0); pushDone();
    startBurst(1'b0, 4'd1, 6'd0, 7'd3, 1'b1);
    waitDrain("desc_drain");
`endif

    repeat (4) tick();
    check("final_queue_empty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
